// File: rtl/stopwatch_ctrl_if.sv
// Button and display-side signals of the stopwatch front end.
// The testbench/board side uses master, stopwatch_ctrl uses slave.
interface stopwatch_ctrl_if #(
  parameter int WIDTH = 20
);
  logic [2:0]       key_n;
  logic             run;
  logic             tick;
  logic [WIDTH-1:0] ms_count;
  logic [WIDTH-1:0] disp_count;
  logic             lap_active;

  modport master (
    output key_n,
    input  run, tick, ms_count, disp_count, lap_active
  );

  modport slave (
    input  key_n,
    output run, tick, ms_count, disp_count, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: key sync/debounce, IDLE/RUNNING/STOPPED FSM, 1 ms prescaler, ms counter.
// Optional lap-freeze display feature is built when macro LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000,
  parameter int WIDTH           = 20,
  parameter int MAX_COUNT       = 999999
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);
  localparam int NUM_KEYS = 3;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, STOPPED = 2'd2} state_t;

  logic [NUM_KEYS-1:0]         key_raw;
  logic [NUM_KEYS-1:0][1:0]    sync;
  logic [NUM_KEYS-1:0]         stable;
  logic [NUM_KEYS-1:0]         stable_d;
  logic [NUM_KEYS-1:0]         press;
  logic [NUM_KEYS-1:0][CW-1:0] cnt;

  assign key_raw = bus.key_n;

  // Per key: 2-flop sync, then accept a level only after it held for DEBOUNCE_CYCLES.
  // press fires one cycle after stable falls, so a held key gives exactly one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '1;
      stable   <= '1;
      stable_d <= '1;
      press    <= '0;
      cnt      <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        sync[i]     <= {sync[i][0], key_raw[i]};
        stable_d[i] <= stable[i];
        press[i]    <= stable_d[i] & ~stable[i];
        if (sync[i][1] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync[i][1];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  state_t           state;
  logic             run_q;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] ms;
  logic             tick_w;
  logic             start_ev, stop_ev, clear_ev;
  logic             stop_acc, start_acc, clear_acc;

  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign clear_ev = press[2];

  // Priority stop > start > clear; a lower event in the same cycle is dropped.
  assign stop_acc  = stop_ev && (state == RUNNING);
  assign start_acc = !stop_ev && start_ev && (state != RUNNING);
  assign clear_acc = !stop_ev && !start_ev && clear_ev;

  assign tick_w = run_q && (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      run_q <= 1'b0;
      pre   <= '0;
      ms    <= '0;
    end else begin
      if (tick_w) begin
        pre <= '0;
        ms  <= (ms == MAX_V) ? '0 : ms + 1'b1;
      end else if (run_q) begin
        pre <= pre + 1'b1;
      end else begin
        pre <= '0;
      end

      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= RUNNING;
            run_q <= 1'b1;
          end
        end
        RUNNING: begin
          if (stop_acc) begin
            state <= STOPPED;
            run_q <= 1'b0;
          end
        end
        STOPPED: begin
          if (start_acc) begin
            state <= RUNNING;
            run_q <= 1'b1;
          end else if (clear_acc) begin
            state <= IDLE;
            ms    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run      = run_q;
  assign bus.tick     = tick_w;
  assign bus.ms_count = ms;

`ifdef LAP_EN
  logic             lap_q;
  logic [WIDTH-1:0] lap_reg;
  logic             lap_toggle;
  logic             lap_kill;

  assign lap_toggle = clear_acc && (state == RUNNING);
  assign lap_kill   = stop_acc || (clear_acc && (state == STOPPED));

  // Captured ms is the pre-increment value when a tick lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q   <= 1'b0;
      lap_reg <= '0;
    end else if (lap_kill) begin
      lap_q <= 1'b0;
    end else if (lap_toggle) begin
      lap_q <= ~lap_q;
      if (!lap_q) lap_reg <= ms;
    end
  end

  assign bus.lap_active = lap_q;
  assign bus.disp_count = lap_q ? lap_reg : ms;
`else
  assign bus.lap_active = 1'b0;
  assign bus.disp_count = ms;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5, MAX_COUNT=9.
module tb_stopwatch_ctrl;
  localparam int W = 20;
`ifdef LAP_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if #(.WIDTH(W)) bus ();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(5),
    .WIDTH(W),
    .MAX_COUNT(9)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic test_reset();
    reset = 1'b1;
    bus.key_n = 3'b111;
    repeat (3) @(negedge clk);
    total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", bus.run); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    total++; if (bus.ms_count !== 20'd0) begin bad++; $display("FAIL reset_ms got=%0d exp=0", bus.ms_count); end
    total++; if (bus.disp_count !== 20'd0) begin bad++; $display("FAIL reset_disp got=%0d exp=0", bus.disp_count); end
    total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap got=%b exp=0", bus.lap_active); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL post_reset_run got=%b exp=0", bus.run); end
  endtask

  task automatic test_short_press();
    int seen;
    seen = 0;
    bus.key_n = 3'b110;
    repeat (3) @(negedge clk);
    bus.key_n = 3'b111;
    repeat (12) begin
      @(negedge clk);
      if (bus.run !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL short_press run_cycles got=%0d exp=0", seen); end
  endtask

  // Start press at k=0; run rises after edge 8; tick every 5 cycles; wraps at 10.
  task automatic test_start_count();
    int ticks;
    ticks = 0;
    bus.key_n = 3'b110;
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      if (k == 10) bus.key_n = 3'b111;
      if (k >= 8 && k <= 43 && bus.tick === 1'b1) ticks++;
      if (k == 7) begin
        total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL start_early run got=%b exp=0", bus.run); end
      end
      if (k == 8) begin
        total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL start_latency run got=%b exp=1", bus.run); end
      end
      if (k == 11) begin
        total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL tick_early got=%b exp=0", bus.tick); end
      end
      if (k == 12) begin
        total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL tick_first got=%b exp=1", bus.tick); end
      end
      if (k == 43) begin
        total++; if (ticks !== 7) begin bad++; $display("FAIL tick_count got=%0d exp=7", ticks); end
        total++; if (bus.ms_count !== 20'd7) begin bad++; $display("FAIL ms_35 got=%0d exp=7", bus.ms_count); end
        total++; if (bus.disp_count !== 20'd7) begin bad++; $display("FAIL disp_35 got=%0d exp=7", bus.disp_count); end
      end
      if (k == 53) begin
        total++; if (bus.ms_count !== 20'd9) begin bad++; $display("FAIL ms_max got=%0d exp=9", bus.ms_count); end
      end
      if (k == 58) begin
        total++; if (bus.ms_count !== 20'd0) begin bad++; $display("FAIL ms_wrap got=%0d exp=0", bus.ms_count); end
        total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL run_after_wrap got=%b exp=1", bus.run); end
      end
    end
  endtask

  // Start and stop complete debounce together: stop wins. One tick lands before it.
  task automatic test_stop_start_same();
    int ticks;
    ticks = 0;
    bus.key_n = 3'b100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 10) bus.key_n = 3'b111;
      if (k >= 9 && bus.tick === 1'b1) ticks++;
      if (k == 7) begin
        total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL dual_before run got=%b exp=1", bus.run); end
      end
      if (k == 8) begin
        total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL dual_stop run got=%b exp=0", bus.run); end
        total++; if (bus.ms_count !== 20'd1) begin bad++; $display("FAIL dual_ms got=%0d exp=1", bus.ms_count); end
      end
    end
    total++; if (ticks !== 0) begin bad++; $display("FAIL stopped_ticks got=%0d exp=0", ticks); end
    total++; if (bus.ms_count !== 20'd1) begin bad++; $display("FAIL stopped_hold got=%0d exp=1", bus.ms_count); end
  endtask

  task automatic test_clear_idle();
    bus.key_n = 3'b011;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 10) bus.key_n = 3'b111;
      if (k == 7) begin
        total++; if (bus.ms_count !== 20'd1) begin bad++; $display("FAIL clear_before got=%0d exp=1", bus.ms_count); end
      end
      if (k == 8) begin
        total++; if (bus.ms_count !== 20'd0) begin bad++; $display("FAIL clear_ms got=%0d exp=0", bus.ms_count); end
        total++; if (bus.disp_count !== 20'd0) begin bad++; $display("FAIL clear_disp got=%0d exp=0", bus.disp_count); end
      end
    end
    total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL idle_run got=%b exp=0", bus.run); end
  endtask

  task automatic test_reset_mid();
    bus.key_n = 3'b110;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 10) bus.key_n = 3'b111;
    end
    total++; if (bus.ms_count !== 20'd6) begin bad++; $display("FAIL mid_ms got=%0d exp=6", bus.ms_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL mid_reset_run got=%b exp=0", bus.run); end
    total++; if (bus.ms_count !== 20'd0) begin bad++; $display("FAIL mid_reset_ms got=%0d exp=0", bus.ms_count); end
    total++; if (bus.disp_count !== 20'd0) begin bad++; $display("FAIL mid_reset_disp got=%0d exp=0", bus.disp_count); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL mid_reset_tick got=%b exp=0", bus.tick); end
    repeat (8) @(negedge clk);
    total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=%b exp=0", bus.run); end
    total++; if (bus.ms_count !== 20'd0) begin bad++; $display("FAIL mid_reset_ms_hold got=%0d exp=0", bus.ms_count); end
  endtask

  // Clear in RUNNING at ms=3 and again at ms=8; lap freezes the display only with LAP_EN.
  task automatic test_lap();
    bus.key_n = 3'b110;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 10) bus.key_n = 3'b111;
      if (k == 16) bus.key_n = 3'b011;
      if (k == 26) bus.key_n = 3'b111;
      if (k == 40) bus.key_n = 3'b011;
      if (k == 46) bus.key_n = 3'b111;
      if (k == 23) begin
        total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL lap_before got=%b exp=0", bus.lap_active); end
      end
      if (k == 24) begin
        total++; if (bus.lap_active !== LAP) begin bad++; $display("FAIL lap_set got=%b exp=%b", bus.lap_active, LAP); end
        total++; if (bus.disp_count !== 20'd3) begin bad++; $display("FAIL lap_disp3 got=%0d exp=3", bus.disp_count); end
        total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL lap_run got=%b exp=1", bus.run); end
      end
      if (k == 38) begin
        total++; if (bus.ms_count !== 20'd6) begin bad++; $display("FAIL lap_ms6 got=%0d exp=6", bus.ms_count); end
        total++; if (bus.disp_count !== (LAP ? 20'd3 : 20'd6)) begin
          bad++; $display("FAIL lap_frozen got=%0d exp=%0d", bus.disp_count, LAP ? 3 : 6);
        end
      end
      if (k == 47) begin
        total++; if (bus.lap_active !== LAP) begin bad++; $display("FAIL lap_hold got=%b exp=%b", bus.lap_active, LAP); end
      end
      if (k == 48) begin
        total++; if (bus.lap_active !== 1'b0) begin bad++; $display("FAIL lap_clear got=%b exp=0", bus.lap_active); end
        total++; if (bus.ms_count !== 20'd8) begin bad++; $display("FAIL lap_ms8 got=%0d exp=8", bus.ms_count); end
        total++; if (bus.disp_count !== 20'd8) begin bad++; $display("FAIL lap_follow got=%0d exp=8", bus.disp_count); end
        total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL lap_run2 got=%b exp=1", bus.run); end
      end
    end
  endtask

  initial begin
    bus.key_n = 3'b111;
    test_reset();
    test_short_press();
    test_start_count();
    test_stop_start_same();
    test_clear_idle();
    test_reset_mid();
    test_lap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
